// File: rtl/add_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : add_sub_pkg
// Brief    : Shared types, defaults and helpers for the pipelined add/sub unit.
// Revision : 1.0 - initial release
// ============================================================================
package add_sub_pkg;

    localparam int c_DEFAULT_WIDTH = 32;
    localparam int c_DEFAULT_CHUNK = 8;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    // Guarded so a bad configuration still elaborates far enough to report it.
    function automatic int stages(input int width, input int chunk);
        int n;
        if (chunk < 1) begin
            return 1;
        end
        n = width / chunk;
        return (n < 1) ? 1 : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : chunk_adder
// Brief    : Combinational N-bit ripple of full-adder cells.
// Revision : 1.0 - initial release
// ============================================================================
module chunk_adder
    import add_sub_pkg::*;
#(
    parameter int N = c_DEFAULT_CHUNK
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    always_comb begin : p_ripple
        logic w_carry;
        w_carry  = cin;
        s        = '0;
        c_msb_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                c_msb_in = w_carry;
            end
            s[i]    = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        cout = w_carry;
    end

endmodule
`default_nettype wire

// File: rtl/pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_add_sub
// Brief    : Carry-skewed pipelined signed add/subtract, CHUNK bits per stage,
//            valid/ready on both sides, carry/overflow/zero/negative flags.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH,
    parameter int CHUNK = c_DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int c_STAGES = stages(WIDTH, CHUNK);

    if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
        $error("pipelined_add_sub: WIDTH must be a positive multiple of CHUNK");
    end

    // Index 0 is the operand register; index k+1 is the output of stage k.
    logic             valid_q [c_STAGES+1];
    logic             valid_d [c_STAGES+1];
    logic [WIDTH-1:0] sum_q   [c_STAGES+1];
    logic [WIDTH-1:0] sum_d   [c_STAGES+1];
    logic [WIDTH-1:0] a_q     [c_STAGES];
    logic [WIDTH-1:0] a_d     [c_STAGES];
    logic [WIDTH-1:0] b_q     [c_STAGES];
    logic [WIDTH-1:0] b_d     [c_STAGES];
    logic             carry_q [c_STAGES];
    logic             carry_d [c_STAGES];
    flags_t           flags_q;
    flags_t           flags_d;

    logic [CHUNK-1:0] w_s  [c_STAGES];
    logic             w_co [c_STAGES];
    logic             w_msb_carry;
    logic             w_stall;

    for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
        if (k == c_STAGES - 1) begin : g_last
            chunk_adder #(.N(CHUNK)) u_add (
                .a        (a_q[k][k*CHUNK +: CHUNK]),
                .b        (b_q[k][k*CHUNK +: CHUNK]),
                .cin      (carry_q[k]),
                .s        (w_s[k]),
                .cout     (w_co[k]),
                .c_msb_in (w_msb_carry)
            );
        end else begin : g_mid
            logic w_msb_carry_unused;
            chunk_adder #(.N(CHUNK)) u_add (
                .a        (a_q[k][k*CHUNK +: CHUNK]),
                .b        (b_q[k][k*CHUNK +: CHUNK]),
                .cin      (carry_q[k]),
                .s        (w_s[k]),
                .cout     (w_co[k]),
                .c_msb_in (w_msb_carry_unused)
            );
        end
    end

    // A stalled output freezes the whole pipe, so every stage holds together.
    assign w_stall  = valid_q[c_STAGES] && !out_ready;
    assign in_ready = !w_stall;

    always_comb begin
        valid_d[0] = in_valid;
        a_d[0]     = a;
        b_d[0]     = sub ? ~b : b;
        carry_d[0] = sub ? 1'b1 : carry_in;
        sum_d[0]   = '0;
        for (int k = 0; k < c_STAGES; k++) begin
            valid_d[k+1]                    = valid_q[k];
            sum_d[k+1]                      = sum_q[k];
            sum_d[k+1][k*CHUNK +: CHUNK]    = w_s[k];
        end
        for (int k = 1; k < c_STAGES; k++) begin
            a_d[k]     = a_q[k-1];
            b_d[k]     = b_q[k-1];
            carry_d[k] = w_co[k-1];
        end
        flags_d.carry    = w_co[c_STAGES-1];
        flags_d.overflow = w_msb_carry ^ w_co[c_STAGES-1];
        flags_d.zero     = (sum_d[c_STAGES] == '0);
        flags_d.negative = sum_d[c_STAGES][WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j <= c_STAGES; j++) begin
                valid_q[j] <= 1'b0;
                sum_q[j]   <= '0;
            end
            for (int j = 0; j < c_STAGES; j++) begin
                a_q[j]     <= '0;
                b_q[j]     <= '0;
                carry_q[j] <= 1'b0;
            end
            flags_q <= '0;
        end else if (!w_stall) begin
            for (int j = 0; j <= c_STAGES; j++) begin
                valid_q[j] <= valid_d[j];
                if (valid_d[j]) begin
                    sum_q[j] <= sum_d[j];
                end
            end
            for (int j = 0; j < c_STAGES; j++) begin
                if (valid_d[j]) begin
                    a_q[j]     <= a_d[j];
                    b_q[j]     <= b_d[j];
                    carry_q[j] <= carry_d[j];
                end
            end
            if (valid_d[c_STAGES]) begin
                flags_q <= flags_d;
            end
        end
    end

    assign out_valid = valid_q[c_STAGES];
    assign sum       = sum_q[c_STAGES];
    assign carry_out = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_add_sub
// Brief    : Directed self-checking bench for pipelined_add_sub (32/8 and 8/8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_add_sub;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        sub, carry_in;
    logic        out_valid, out_ready;
    logic [31:0] sum;
    logic        carry_out, overflow, zero, negative;

    logic        in_valid2, in_ready2;
    logic [7:0]  a2, b2;
    logic        sub2, carry_in2;
    logic        out_valid2, out_ready2;
    logic [7:0]  sum2;
    logic        carry_out2, overflow2, zero2, negative2;

    int          n_tests;
    int          n_fail;
    int          idx, recv;
    logic        acc, ox, was_stall;
    logic [31:0] held, got;

    pipelined_add_sub #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative)
    );

    pipelined_add_sub #(.WIDTH(8), .CHUNK(8)) u_dut_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .sub       (sub2),
        .carry_in  (carry_in2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .carry_out (carry_out2),
        .overflow  (overflow2),
        .zero      (zero2),
        .negative  (negative2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One beat through an idle pipe; result must appear exactly 4 edges later.
    task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic tsub, input logic tcin, input logic [31:0] esum,
                           input logic ec, input logic eov, input logic ez, input logic en);
        a = ta; b = tb_v; sub = tsub; carry_in = tcin; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        check_eq($sformatf("%s_early", tag), out_valid, 1'b0);
        tick();
        check_eq($sformatf("%s_valid", tag), out_valid, 1'b1);
        check_eq($sformatf("%s_sum", tag), sum, esum);
        check_eq($sformatf("%s_flags", tag), {carry_out, overflow, zero, negative},
                 {ec, eov, ez, en});
        tick();
        check_eq($sformatf("%s_drain", tag), out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; carry_in = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; carry_in2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_out_valid", out_valid, 1'b0);
        check_eq("reset_sum", sum, 32'h0);
        check_eq("reset_flags", {carry_out, overflow, zero, negative}, 4'b0000);
        check_eq("reset_in_ready", in_ready, 1'b1);
        check_eq("reset_s1_valid", out_valid2, 1'b0);

        run_one("add_carry_chain", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 0, 0, 0, 0);
        run_one("add_ovf",         32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 0, 1, 0, 1);
        run_one("add_wrap",        32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1, 0, 1, 0);
        run_one("add_cin",         32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0003, 0, 0, 0, 0);
        run_one("sub_neg",         32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 0, 0, 0, 1);
        run_one("sub_zero",        32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1, 0, 1, 0);
        run_one("sub_pos",         32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0002, 1, 0, 0, 0);
        run_one("sub_ovf",         32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1, 1, 0, 0);

        // Eight back-to-back beats with the sink stalled in cycles 5..7.
        idx = 0; recv = 0; was_stall = 1'b0; held = '0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = (idx < 8);
            a = 32'(idx); b = 32'(idx); sub = 1'b0; carry_in = 1'b0;
            #1;
            if (was_stall) check_eq("b2b_hold", sum, held);
            was_stall = out_valid && !out_ready;
            if (was_stall) begin
                check_eq("b2b_in_ready", in_ready, 1'b0);
                held = sum;
            end
            acc = in_valid && in_ready;
            ox  = out_valid && out_ready;
            got = sum;
            tick();
            if (acc) idx++;
            if (ox) begin
                check_eq($sformatf("b2b_res%0d", recv), got, 64'(2 * recv));
                recv++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check_eq("b2b_count", recv, 8);

        // Reset with three beats in flight; the beat offered during reset is dropped.
        for (int i = 0; i < 3; i++) begin
            a = 32'(10 + i); b = 32'h1; in_valid = 1'b1;
            tick();
        end
        rst = 1'b1; a = 32'd100; b = 32'd100;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_sum", sum, 32'h0);
        check_eq("rst_flags", {carry_out, overflow, zero, negative}, 4'b0000);
        check_eq("rst_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("rst_no_stale", out_valid, 1'b0);
        end
        run_one("rst_after", 32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 0, 0, 0, 0);

        // Single-stage configuration: 1-cycle latency.
        a2 = 8'h7F; b2 = 8'h01; in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        check_eq("s1_early", out_valid2, 1'b0);
        tick();
        check_eq("s1_valid", out_valid2, 1'b1);
        check_eq("s1_sum", sum2, 8'h80);
        check_eq("s1_flags", {carry_out2, overflow2, zero2, negative2}, 4'b0101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
